// File: rtl/xeng_corr_apply.sv
`default_nettype none
// ============================================================================
//  Module   : xeng_corr_apply
//  Brief    : Subtracts per-baseline offset-binary corrections (re/im for
//             xx,xy,yx,yy) from X-engine accumulated cross-products. Output
//             is saturated to OUT_WIDTH. Tracks each sample's baseline
//             position within the accumulation window and flags buffer
//             select changes that happen mid-window.
//  Revision : 1.0  initial release
// ============================================================================
module xeng_corr_apply #(
    parameter int ACC_WIDTH            = 24,
    parameter int CORRECTION_ACC_WIDTH = 16,
    parameter int OUT_WIDTH            = 24,
    parameter int N_ANTS               = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sync,
    input  logic                                din_vld,
    input  logic [4*ACC_WIDTH-1:0]              din_re,
    input  logic [4*ACC_WIDTH-1:0]              din_im,
    input  logic [4*CORRECTION_ACC_WIDTH-1:0]   corr_re,
    input  logic [4*CORRECTION_ACC_WIDTH-1:0]   corr_im,
    input  logic                                last_triangle,
    input  logic                                buf_sel,
    output logic [4*OUT_WIDTH-1:0]              dout_re,
    output logic [4*OUT_WIDTH-1:0]              dout_im,
    output logic                                dout_vld,
    output logic                                dout_first,
    output logic                                dout_last,
    output logic [$clog2(N_ANTS/2+1)-1:0]       bl_idx,
    output logic                                sat_flag,
    output logic                                seq_err
);

    // Window geometry and datapath widths.
    localparam int c_N_TAPS = N_ANTS / 2 + 1;
    localparam int c_BL_W   = $clog2(c_N_TAPS);
    localparam int c_DIFF_W = ACC_WIDTH + 1;
    localparam int c_LANES  = 8;                 // lanes 0..3 real, 4..7 imag
    localparam int c_CW     = CORRECTION_ACC_WIDTH;

    localparam logic [c_BL_W-1:0]    c_BL_LAST = c_BL_W'(c_N_TAPS - 1);
    localparam logic [c_BL_W-1:0]    c_BL_ONE  = c_BL_W'(1);
    localparam logic [OUT_WIDTH-1:0] c_OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic                              r1_vld;
    logic                              r1_sync;
    logic                              r1_last_tri;
    logic                              r1_buf_sel;
    logic [c_LANES*ACC_WIDTH-1:0]      r1_din;
    logic [c_LANES*c_CW-1:0]           r1_corr;

    // Baseline tracking state
    logic [c_BL_W-1:0]                 r_bl_cnt;
    logic                              r_prev_buf_sel;
    logic [c_BL_W-1:0]                 w1_bl;
    logic [c_BL_W-1:0]                 w1_bl_next;
    logic                              w1_seq_evt;

    // Stage 2 registers
    logic                              r2_vld;
    logic                              r2_last_tri;
    logic                              r2_seq_evt;
    logic [c_BL_W-1:0]                 r2_bl;
    logic [c_LANES*c_DIFF_W-1:0]       r2_diff;

    // Combinational datapath
    logic [c_LANES*c_DIFF_W-1:0]       w1_diff;
    logic [c_LANES*OUT_WIDTH-1:0]      w2_sat;
    logic [c_LANES-1:0]                w2_hit;

    // Capture inputs; real lanes in the low half, imaginary in the high half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld      <= 1'b0;
            r1_sync     <= 1'b0;
            r1_last_tri <= 1'b0;
            r1_buf_sel  <= 1'b0;
            r1_din      <= '0;
            r1_corr     <= '0;
        end else begin
            r1_vld      <= din_vld;
            r1_sync     <= sync;
            r1_last_tri <= last_triangle;
            r1_buf_sel  <= buf_sel;
            r1_din      <= {din_im, din_re};
            r1_corr     <= {corr_im, corr_re};
        end
    end

    // A sync sample is baseline 0 regardless of where the counter was.
    assign w1_bl      = r1_sync ? '0 : r_bl_cnt;
    assign w1_bl_next = (w1_bl == c_BL_LAST) ? '0 : (w1_bl + c_BL_ONE);
    // Changing buffers is only legal at the window boundary.
    assign w1_seq_evt = r1_vld && (w1_bl != '0) && (r1_buf_sel != r_prev_buf_sel);

    // Baseline counter moves only on valid samples; a lone sync re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bl_cnt       <= '0;
            r_prev_buf_sel <= 1'b0;
        end else if (r1_vld) begin
            r_bl_cnt       <= w1_bl_next;
            r_prev_buf_sel <= r1_buf_sel;
        end else if (r1_sync) begin
            r_bl_cnt       <= '0;
        end
    end

    // Per-lane subtract and saturate. The difference is one bit wider than
    // the accumulator so it can never wrap before the clamp.
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        logic [c_DIFF_W-1:0] w_d;

        assign w1_diff[i*c_DIFF_W +: c_DIFF_W] =
            c_DIFF_W'($signed(r1_din[i*ACC_WIDTH +: ACC_WIDTH])) -
            c_DIFF_W'($signed(r1_corr[i*c_CW +: c_CW]));

        assign w_d = r2_diff[i*c_DIFF_W +: c_DIFF_W];

        if (OUT_WIDTH >= c_DIFF_W) begin : g_ext
            // Output is wide enough for any difference: sign-extend only.
            assign w2_sat[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(w_d));
            assign w2_hit[i]                        = 1'b0;
        end else begin : g_clamp
            // In range iff every bit from the output sign upward agrees.
            logic [c_DIFF_W-OUT_WIDTH:0] w_top;
            logic                        w_ovf;
            assign w_top      = w_d[c_DIFF_W-1:OUT_WIDTH-1];
            assign w_ovf      = ~((&w_top) | (~|w_top));
            assign w2_hit[i]  = w_ovf;
            assign w2_sat[i*OUT_WIDTH +: OUT_WIDTH] =
                !w_ovf ? w_d[OUT_WIDTH-1:0] :
                (w_d[c_DIFF_W-1] ? c_OUT_MIN : c_OUT_MAX);
        end
    end

    // Register differences alongside the baseline tag and sequencing event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_vld      <= 1'b0;
            r2_last_tri <= 1'b0;
            r2_seq_evt  <= 1'b0;
            r2_bl       <= '0;
            r2_diff     <= '0;
        end else begin
            r2_vld      <= r1_vld;
            r2_last_tri <= r1_last_tri;
            r2_seq_evt  <= w1_seq_evt;
            r2_bl       <= w1_bl;
            r2_diff     <= w1_diff;
        end
    end

    // Output stage: data and index hold on idle cycles, markers pulse only
    // with valid data, flags are sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_re    <= '0;
            dout_im    <= '0;
            dout_vld   <= 1'b0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            bl_idx     <= '0;
            sat_flag   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            dout_vld   <= r2_vld;
            dout_first <= r2_vld && (r2_bl == '0);
            dout_last  <= r2_vld && (r2_bl == c_BL_LAST) && r2_last_tri;
            if (r2_vld) begin
                dout_re <= w2_sat[4*OUT_WIDTH-1:0];
                dout_im <= w2_sat[8*OUT_WIDTH-1:4*OUT_WIDTH];
                bl_idx  <= r2_bl;
                if (|w2_hit) begin
                    sat_flag <= 1'b1;
                end
                if (r2_seq_evt) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xeng_corr_apply.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_xeng_corr_apply
//  Brief    : Self-checking bench for xeng_corr_apply (OUT_WIDTH=16 so the
//             clamp path is active). An in-order behavioural model predicts
//             every output cycle; directed steps pin literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xeng_corr_apply;

    localparam int AW = 24;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int NA = 32;
    localparam int NT = NA / 2 + 1;
    localparam int BW = $clog2(NT);
    localparam int DEPTH = 8192;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sync = 1'b0;
    logic            din_vld = 1'b0;
    logic            last_triangle = 1'b0;
    logic            buf_sel = 1'b0;
    logic [4*AW-1:0] din_re = '0;
    logic [4*AW-1:0] din_im = '0;
    logic [4*CW-1:0] corr_re = '0;
    logic [4*CW-1:0] corr_im = '0;
    logic [4*OW-1:0] dout_re;
    logic [4*OW-1:0] dout_im;
    logic            dout_vld;
    logic            dout_first;
    logic            dout_last;
    logic [BW-1:0]   bl_idx;
    logic            sat_flag;
    logic            seq_err;

    xeng_corr_apply #(
        .ACC_WIDTH            (AW),
        .CORRECTION_ACC_WIDTH (CW),
        .OUT_WIDTH            (OW),
        .N_ANTS               (NA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sync          (sync),
        .din_vld       (din_vld),
        .din_re        (din_re),
        .din_im        (din_im),
        .corr_re       (corr_re),
        .corr_im       (corr_im),
        .last_triangle (last_triangle),
        .buf_sel       (buf_sel),
        .dout_re       (dout_re),
        .dout_im       (dout_im),
        .dout_vld      (dout_vld),
        .dout_first    (dout_first),
        .dout_last     (dout_last),
        .bl_idx        (bl_idx),
        .sat_flag      (sat_flag),
        .seq_err       (seq_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic check_s(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: processes each sampled input in order and writes
    // the output expected two edges later (third register stage).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [4*OW-1:0] re;
        logic [4*OW-1:0] im;
        logic            vld;
        logic            first;
        logic            last;
        logic [BW-1:0]   bl;
        logic            sat;
        logic            seq;
    } exp_t;

    exp_t exp_q  [DEPTH];
    bit   exp_ok [DEPTH];
    int   cyc = 0;

    int              m_cnt = 0;
    bit              m_prev_bs = 1'b0;
    logic [4*OW-1:0] m_re = '0;
    logic [4*OW-1:0] m_im = '0;
    logic [BW-1:0]   m_bl = '0;
    bit              m_sat = 1'b0;
    bit              m_seq = 1'b0;

    function automatic logic [OW-1:0] sub_sat(input logic [AW-1:0] d, input logic [CW-1:0] c,
                                              inout bit hit);
        longint v;
        longint mx;
        longint mn;
        v  = longint'($signed(d)) - longint'($signed(c));
        mx = (longint'(1) << (OW - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) begin
            hit = 1'b1;
            return OW'(mx);
        end
        if (v < mn) begin
            hit = 1'b1;
            return OW'(mn);
        end
        return OW'(v);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   bl;
        bit   hit;
        cyc = cyc + 1;
        if (rst) begin
            m_cnt = 0; m_prev_bs = 1'b0; m_re = '0; m_im = '0; m_bl = '0;
            m_sat = 1'b0; m_seq = 1'b0;
            for (int k = 0; k < 3; k++) begin
                exp_q[cyc+k]  = '0;
                exp_ok[cyc+k] = 1'b1;
            end
        end else begin
            e   = '0;
            bl  = 0;
            hit = 1'b0;
            if (din_vld) begin
                bl = sync ? 0 : m_cnt;
                if (bl != 0 && buf_sel != m_prev_bs) m_seq = 1'b1;
                m_prev_bs = buf_sel;
                for (int l = 0; l < 4; l++) begin
                    m_re[l*OW +: OW] = sub_sat(din_re[l*AW +: AW], corr_re[l*CW +: CW], hit);
                    m_im[l*OW +: OW] = sub_sat(din_im[l*AW +: AW], corr_im[l*CW +: CW], hit);
                end
                if (hit) m_sat = 1'b1;
                m_bl  = BW'(bl);
                m_cnt = (bl == NT - 1) ? 0 : bl + 1;
                e.vld   = 1'b1;
                e.first = (bl == 0);
                e.last  = (bl == NT - 1) && last_triangle;
            end else if (sync) begin
                m_cnt = 0;
            end
            e.re = m_re; e.im = m_im; e.bl = m_bl; e.sat = m_sat; e.seq = m_seq;
            exp_q[cyc+2]  = e;
            exp_ok[cyc+2] = 1'b1;
        end
    end

    // Observation log of valid outputs for the directed checks.
    logic [BW-1:0] obs_bl[$];
    int n_first = 0;
    int n_last  = 0;

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cyc > 0 && cyc < DEPTH && exp_ok[cyc]) begin
            check($sformatf("data@%0d", cyc), {dout_im, dout_re}, {exp_q[cyc].im, exp_q[cyc].re});
            check($sformatf("ctrl@%0d", cyc), {dout_vld, dout_first, dout_last, bl_idx},
                  {exp_q[cyc].vld, exp_q[cyc].first, exp_q[cyc].last, exp_q[cyc].bl});
            check($sformatf("flags@%0d", cyc), {sat_flag, seq_err}, {exp_q[cyc].sat, exp_q[cyc].seq});
        end
        if (dout_vld) begin
            obs_bl.push_back(bl_idx);
            n_first += int'(dout_first);
            n_last  += int'(dout_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        sync    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_data();
        din_re = '0; din_im = '0; corr_re = '0; corr_im = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int o0;
        int f0;
        int l0;

        // Reset state
        repeat (3) tick();
        check("rst_vld", dout_vld, 1'b0);
        check("rst_data", {dout_im, dout_re}, '0);
        check("rst_flags", {sat_flag, seq_err, dout_first, dout_last}, 4'b0000);
        check_s("rst_bl", bl_idx, 0);
        rst = 1'b0;
        idle(2);

        // 17-sample window, zero corrections
        clear_data();
        din_re[3*AW +: AW] = AW'(1000);
        o0 = obs_bl.size();
        f0 = n_first;
        for (int i = 0; i < 17; i++) begin
            din_vld = 1'b1;
            sync    = (i == 0);
            tick();
        end
        din_vld = 1'b0; sync = 1'b0;
        tick(); tick();
        check_s("win_vld", dout_vld, 1);
        check_s("win_bl16", bl_idx, 16);
        check_s("win_xx", $signed(dout_re[3*OW +: OW]), 1000);
        tick();
        check_s("hold_xx", $signed(dout_re[3*OW +: OW]), 1000);
        check_s("hold_vld", dout_vld, 0);
        tick();
        check_s("win_count", obs_bl.size() - o0, 17);
        check_s("win_bl0", obs_bl[o0], 0);
        check_s("win_first", n_first - f0, 1);

        // Signed subtraction
        clear_data();
        din_im[1*AW +: AW]  = AW'(-5);
        corr_im[1*CW +: CW] = CW'(300);
        din_re[0 +: AW]     = AW'(7);
        corr_re[0 +: CW]    = CW'(-9);
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        tick(); tick();
        check_s("sub_im_yx", $signed(dout_im[1*OW +: OW]), -305);
        check_s("sub_re_yy", $signed(dout_re[0 +: OW]), 16);
        check_s("sat_clear", sat_flag, 0);

        // Saturation both ways, flag sticky
        clear_data();
        din_re[3*AW +: AW] = AW'(40000);
        din_vld = 1'b1;
        tick();
        din_re[3*AW +: AW] = AW'(-40000);
        tick();
        din_vld = 1'b0;
        tick();
        check_s("sat_max", $signed(dout_re[3*OW +: OW]), 32767);
        check_s("sat_flag_set", sat_flag, 1);
        tick();
        check_s("sat_min", $signed(dout_re[3*OW +: OW]), -32768);
        idle(3);
        check_s("sat_sticky", sat_flag, 1);

        // Sync mid-window restarts the count; wrap gives another first
        clear_data();
        o0 = obs_bl.size();
        f0 = n_first;
        for (int i = 0; i < 23; i++) begin
            din_vld = 1'b1;
            sync    = (i == 0 || i == 5);
            tick();
        end
        idle(4);
        check_s("sync_bl4", obs_bl[o0+4], 4);
        check_s("sync_bl5_is0", obs_bl[o0+5], 0);
        check_s("sync_bl16", obs_bl[o0+21], 16);
        check_s("sync_wrap0", obs_bl[o0+22], 0);
        check_s("sync_firsts", n_first - f0, 3);

        // Sync without valid re-arms baseline 0
        sync = 1'b1;
        tick();
        sync = 1'b0;
        din_vld = 1'b1;
        tick();
        idle(4);
        check_s("lone_sync_bl", obs_bl[obs_bl.size()-1], 0);

        // buf_sel toggle at baseline 0 is legal; dout_last on bl 16
        l0 = n_last;
        for (int i = 0; i < 17; i++) begin
            din_vld       = 1'b1;
            sync          = (i == 0);
            buf_sel       = 1'b1;
            last_triangle = (i == 16);
            tick();
        end
        last_triangle = 1'b0;
        idle(4);
        check_s("seq_legal", seq_err, 0);
        check_s("last_pulse", n_last - l0, 1);

        // buf_sel toggle at baseline 9 is an error
        for (int i = 0; i < 17; i++) begin
            din_vld = 1'b1;
            sync    = (i == 0);
            buf_sel = (i < 9);
            tick();
        end
        idle(4);
        check_s("seq_err_set", seq_err, 1);

        // One-cycle reset in the middle of a burst
        for (int i = 0; i < 6; i++) begin
            din_vld = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        check("mid_rst_out", {dout_vld, dout_first, dout_last, sat_flag, seq_err, bl_idx, dout_re, dout_im}, '0);
        rst = 1'b0;
        tick();
        check_s("post_rst_vld1", dout_vld, 0);
        tick();
        check_s("post_rst_vld2", dout_vld, 0);
        tick();
        check_s("post_rst_vld3", dout_vld, 1);
        check_s("post_rst_bl", bl_idx, 0);
        idle(4);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst           = ($urandom_range(0, 399) == 0);
            din_vld       = ($urandom_range(0, 9) < 7);
            sync          = ($urandom_range(0, 29) == 0);
            last_triangle = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 49) == 0) buf_sel = ~buf_sel;
            for (int l = 0; l < 4; l++) begin
                din_re[l*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                   : AW'(int'($urandom_range(0, 40000)) - 20000);
                din_im[l*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                   : AW'(int'($urandom_range(0, 40000)) - 20000);
                corr_re[l*CW +: CW] = CW'($urandom);
                corr_im[l*CW +: CW] = CW'($urandom);
            end
            tick();
        end
        rst = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
